// File: rtl/count_sequencer_if.sv
// count_sequencer_if: control/status bundle for count_sequencer.
// The master drives the controls and the count parameters; the slave reports the count and its flags.
interface count_sequencer_if #(parameter int WIDTH = 4);
    logic             start;
    logic             stop;
    logic             pause;
    logic             dir;
    logic             mode;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             wrap;
    modport master (
        output start, stop, pause, dir, mode, load_val, limit,
        input  q, busy, done, wrap
    );
    modport slave (
        input  start, stop, pause, dir, mode, load_val, limit,
        output q, busy, done, wrap
    );
endinterface

// File: rtl/count_sequencer.sv
// count_sequencer: up/down counter sequenced by start/stop/pause, one-shot or auto-reload.
// rst is asynchronous and active-low; every output is registered.
module count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    count_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
    state_t           state;
    logic             dir_r;
    logic             mode_r;
    logic [WIDTH-1:0] lim_r;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bus.q    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.wrap <= 1'b0;
            dir_r    <= 1'b0;
            mode_r   <= 1'b0;
            lim_r    <= '0;
        end else begin
            bus.done <= 1'b0;
            bus.wrap <= 1'b0;
            // stop outranks everything and leaves q frozen where it was
            if (bus.stop) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
            end else if (bus.start && (state == IDLE || state == DONE)) begin
                state    <= RUN;
                bus.busy <= 1'b1;
                bus.q    <= bus.load_val;
                dir_r    <= bus.dir;
                mode_r   <= bus.mode;
                lim_r    <= bus.limit;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    DONE: state <= IDLE;
                    HOLD: state <= bus.pause ? HOLD : RUN;
                    RUN: begin
                        if (bus.pause) begin
                            state <= HOLD;
                        end else if (bus.q == lim_r && mode_r) begin
                            bus.q    <= bus.load_val;
                            bus.wrap <= 1'b1;
                        end else if (bus.q == lim_r) begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end else begin
                            bus.q <= bus.q + (dir_r ? {WIDTH{1'b1}} : WIDTH'(1));
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_count_sequencer;
    localparam int W   = 4;
    localparam int MOD = 1 << W;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   passed = 0;
    count_sequencer_if #(.WIDTH(W)) bus ();
    count_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // model: active covers RUN and HOLD, holding marks HOLD, m_done marks the DONE cycle
    int m_q, m_lim;
    bit m_active, m_holding, m_done, m_wrap, m_dir, m_mode;

    task automatic model_reset();
        m_q = 0; m_lim = 0; m_active = 0; m_holding = 0;
        m_done = 0; m_wrap = 0; m_dir = 0; m_mode = 0;
    endtask

    task automatic model_edge();
        m_done = 0;
        m_wrap = 0;
        if (bus.stop) begin
            m_active = 0; m_holding = 0;
        end else if (bus.start && !m_active) begin
            m_q = int'(bus.load_val); m_lim = int'(bus.limit);
            m_dir = bus.dir; m_mode = bus.mode;
            m_active = 1; m_holding = 0;
        end else if (m_active && m_holding) begin
            m_holding = bus.pause;
        end else if (m_active && bus.pause) begin
            m_holding = 1;
        end else if (m_active && m_q == m_lim) begin
            if (m_mode) begin m_q = int'(bus.load_val); m_wrap = 1; end
            else begin m_active = 0; m_done = 1; end
        end else if (m_active) begin
            m_q = (m_q + (m_dir ? MOD - 1 : 1)) % MOD;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.stop = 0; bus.pause = 0;
        bus.dir = 0; bus.mode = 0; bus.load_val = '0; bus.limit = '0;
    endtask

    task automatic kick(input int lv, input int lim, input bit d, input bit m);
        bus.load_val = W'(lv); bus.limit = W'(lim); bus.dir = d; bus.mode = m;
        bus.start = 1;
        tick();
        bus.start = 0;
    endtask

    task automatic halt();
        bus.stop = 1;
        tick();
        bus.stop = 0;
    endtask

    task automatic test_reset();
        total++;
        if (bus.q !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wrap !== 1'b0)
            $display("FAIL reset_initial q=%0d busy=%b done=%b wrap=%b want 0/0/0/0", bus.q, bus.busy, bus.done, bus.wrap);
        else passed++;
        rst = 1;
        kick(5, 12, 0, 0);
        total++;
        if (bus.q !== 4'd5 || bus.busy !== 1'b1) $display("FAIL reset_setup q=%0d busy=%b want 5/1", bus.q, bus.busy);
        else passed++;
        #2 rst = 0;
        model_reset();
        #1;
        total++;
        if (bus.q !== 4'd0 || bus.busy !== 1'b0) $display("FAIL reset_async q=%0d busy=%b want 0/0", bus.q, bus.busy);
        else passed++;
        tick();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.q !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
                $display("FAIL reset_release_idle q=%0d busy=%b done=%b want 0/0/0", bus.q, bus.busy, bus.done);
            else passed++;
        end
    endtask

    task automatic test_up_oneshot();
        int exp_q[4] = '{3, 4, 5, 6};
        kick(3, 6, 0, 0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.q !== W'(exp_q[i]) || bus.busy !== 1'b1 || bus.done !== 1'b0)
                $display("FAIL up_oneshot_step%0d q=%0d busy=%b done=%b want %0d/1/0", i, bus.q, bus.busy, bus.done, exp_q[i]);
            else passed++;
            if (i < 3) tick();
        end
        tick();
        total++;
        if (bus.done !== 1'b1 || bus.q !== 4'd6 || bus.busy !== 1'b0)
            $display("FAIL up_oneshot_done done=%b q=%0d busy=%b want 1/6/0", bus.done, bus.q, bus.busy);
        else passed++;
        tick();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL up_oneshot_after done=%b busy=%b want 0/0", bus.done, bus.busy);
        else passed++;
    endtask

    task automatic test_down_reload();
        int exp_q[6] = '{2, 1, 0, 2, 1, 0};
        bit exp_w[6] = '{0, 0, 0, 1, 0, 0};
        kick(2, 0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (bus.q !== W'(exp_q[i]) || bus.wrap !== exp_w[i] || bus.done !== 1'b0)
                $display("FAIL down_reload_step%0d q=%0d wrap=%b done=%b want %0d/%b/0", i, bus.q, bus.wrap, bus.done, exp_q[i], exp_w[i]);
            else passed++;
            if (i < 5) tick();
        end
        halt();
    endtask

    task automatic test_wraparound();
        int exp_q[4] = '{14, 15, 0, 1};
        kick(14, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.q !== W'(exp_q[i])) $display("FAIL wraparound_step%0d q=%0d want %0d", i, bus.q, exp_q[i]);
            else passed++;
            tick();
        end
        total++;
        if (bus.done !== 1'b1 || bus.q !== 4'd1) $display("FAIL wraparound_done done=%b q=%0d want 1/1", bus.done, bus.q);
        else passed++;
        tick();
    endtask

    task automatic test_pause();
        kick(0, 15, 0, 0);
        repeat (4) tick();
        total++;
        if (bus.q !== 4'd4) $display("FAIL pause_setup q=%0d want 4", bus.q);
        else passed++;
        bus.pause = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.q !== 4'd4 || bus.busy !== 1'b1) $display("FAIL pause_hold%0d q=%0d busy=%b want 4/1", i, bus.q, bus.busy);
            else passed++;
        end
        bus.pause = 0;
        tick();
        total++;
        if (bus.q !== 4'd4 || bus.busy !== 1'b1) $display("FAIL pause_return q=%0d busy=%b want 4/1", bus.q, bus.busy);
        else passed++;
        tick();
        total++;
        if (bus.q !== 4'd5) $display("FAIL pause_resume q=%0d want 5", bus.q);
        else passed++;
        halt();
    endtask

    task automatic test_stop_priority();
        kick(3, 4, 0, 0);
        tick();
        total++;
        if (bus.q !== 4'd4 || bus.busy !== 1'b1) $display("FAIL stop_setup q=%0d busy=%b want 4/1", bus.q, bus.busy);
        else passed++;
        bus.stop = 1; bus.start = 1;
        tick();
        bus.stop = 0; bus.start = 0;
        total++;
        if (bus.q !== 4'd4 || bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL stop_priority q=%0d done=%b busy=%b want 4/0/0", bus.q, bus.done, bus.busy);
        else passed++;
        tick();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 4'd4)
            $display("FAIL stop_after done=%b busy=%b q=%0d want 0/0/4", bus.done, bus.busy, bus.q);
        else passed++;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            bus.start    = ($urandom_range(0, 5) == 0);
            bus.stop     = ($urandom_range(0, 15) == 0);
            bus.pause    = ($urandom_range(0, 5) == 0);
            bus.dir      = 1'($urandom);
            bus.mode     = 1'($urandom);
            bus.load_val = W'($urandom);
            bus.limit    = W'($urandom);
            tick();
            total++;
            if (bus.q !== W'(m_q) || bus.busy !== m_active || bus.done !== m_done || bus.wrap !== m_wrap) begin
                if (bad < 10)
                    $display("FAIL random_cycle%0d q=%0d busy=%b done=%b wrap=%b want %0d/%b/%b/%b",
                             i, bus.q, bus.busy, bus.done, bus.wrap, m_q, m_active, m_done, m_wrap);
                bad++;
            end else passed++;
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #2;
        test_reset();
        test_up_oneshot();
        test_down_reload();
        test_wraparound();
        test_pause();
        test_stop_priority();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: begin a count sequence.
REQ-005 The block SHALL have port stop, input, 1 bit: abort the sequence and return to IDLE.
REQ-006 The block SHALL have port pause, input, 1 bit: freeze the count while high.
REQ-007 The block SHALL have port dir, input, 1 bit: 0 counts up, 1 counts down; sampled only at start.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 one-shot, 1 auto-reload; sampled only at start.
REQ-009 The block SHALL have port load_val, input, WIDTH bits: start value; sampled at start and at each auto-reload.
REQ-010 The block SHALL have port limit, input, WIDTH bits: terminal value; sampled at start.
REQ-011 The block SHALL have port q, output, WIDTH bits: registered count value.
REQ-012 The block SHALL have port busy, output, 1 bit: high in states RUN and HOLD.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse marking one-shot completion.
REQ-014 The block SHALL have port wrap, output, 1 bit: one-cycle pulse marking each auto-reload.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN, HOLD and DONE; q, busy, done and wrap SHALL all be registered.
REQ-016 Input priority per edge SHALL be stop > start > pause > terminal check > count step.
REQ-017 In IDLE or DONE with start=1 and stop=0, the block SHALL load q to load_val, latch dir, mode and limit, and enter RUN on the same edge.
REQ-018 In IDLE without start, q SHALL hold its value.
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE, unless start is accepted on that cycle.
REQ-020 In RUN with pause=0, the block SHALL compare q with the latched limit on each edge.
- If q != limit: q <= q+1 when dir=0, q <= q-1 when dir=1.
- Arithmetic SHALL be modulo 2^WIDTH, so 15+1 wraps to 0 and 0-1 wraps to 15 for WIDTH=4.
REQ-021 In RUN with q == limit and mode=0, the block SHALL enter DONE and hold q at limit; done SHALL be 1 for exactly the DONE cycle.
REQ-022 In RUN with q == limit and mode=1, the block SHALL set q to the current load_val, stay in RUN, and assert wrap for exactly the next cycle.
REQ-023 In RUN with pause=1, the block SHALL enter HOLD; in HOLD q SHALL hold, and pause=0 SHALL return the block to RUN.
- The count SHALL resume with the first RUN edge after the return.
REQ-024 stop=1 in RUN, HOLD or DONE SHALL move the block to IDLE on that edge, with the following effects.
- q SHALL hold its value.
- No done or wrap pulse SHALL be generated on that edge, even if the terminal condition was met.
REQ-025 start while in RUN or HOLD SHALL be ignored.
REQ-026 If load_val == limit at start, the block SHALL detect the terminal condition on the first RUN edge.
- One-shot: done pulses 2 cycles after start.
- Auto-reload: q stays at load_val and wrap pulses every cycle.
REQ-027 Changes to dir, mode or limit during RUN or HOLD SHALL have no effect until the next accepted start.

Reset
REQ-028 While rst=0, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, q=0, busy=0, done=0, wrap=0 and clear the latched dir, mode and limit.
REQ-029 On rst deassertion, the block SHALL remain in IDLE until an accepted start.
REQ-030 Reset asserted mid-sequence SHALL abort the sequence with no done or wrap pulse.

Verification
REQ-031 Bench scenario, reset: drive rst=0 while RUN with q=5 -> q=0, busy=0 before the next clock edge; after release, the block stays in IDLE.
REQ-032 Bench scenario, up one-shot: load_val=3, limit=6, dir=0, mode=0, pulse start.
- q SHALL read 3,4,5,6 on successive edges.
- The next edge SHALL give done=1 with q=6.
- The edge after that SHALL give done=0, busy=0.
REQ-033 Bench scenario, down auto-reload: load_val=2, limit=0, dir=1, mode=1 -> q SHALL read 2,1,0,2,1,0, with wrap=1 in each cycle where q returns to 2; done SHALL stay 0.
REQ-034 Bench scenario, wrap-around: WIDTH=4, load_val=14, limit=1, dir=0, mode=0 -> q SHALL read 14,15,0,1, then done pulses.
REQ-035 Bench scenario, pause: run up from 0, hold pause=1 for 3 cycles at q=4 -> q SHALL stay 4 with busy=1, then resume at 5.
REQ-036 Bench scenario, stop priority: assert stop and start together on the edge where q == limit with mode=0 -> IDLE, q=limit, done=0, busy=0.
